// File: rtl/ps2_move_arbiter.sv
// PS/2 set-2 scan-code parser feeding a two-player move scheduler.
// Each game tick issues at most one move per player over a shared valid/ready port.
module ps2_move_arbiter (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] KEY_CODE,
    input  logic       KEY_VALID,
    input  logic       TICK,
    output logic       MOVE_VALID,
    output logic       MOVE_PLAYER,
    output logic [1:0] MOVE_DIR,
    input  logic       MOVE_READY,
    output logic [3:0] HELD_A,
    output logic [3:0] HELD_B,
    output logic       OVERRUN
);

    typedef enum logic [1:0] {P_IDLE, P_BRK, P_EXT, P_EXTBRK} pst_e;
    typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND} sst_e;

    pst_e       pst_q, pst_d;
    logic [3:0] held_a_q, held_a_d, held_b_q, held_b_d;

    sst_e       sst_q;
    logic       valid_q, player_q, ptr_q, both_q, ovr_q;
    logic [1:0] dir_q, sec_dir_q;

    logic       hit, hit_b;
    logic [1:0] hit_idx;
    logic       req_a, req_b, hs;
    logic [1:0] dir_a, dir_b;

    function automatic logic [1:0] pick_dir(input logic [3:0] h);
        if (h[0])      pick_dir = 2'd0;
        else if (h[1]) pick_dir = 2'd1;
        else if (h[2]) pick_dir = 2'd2;
        else           pick_dir = 2'd3;
    endfunction

    always_comb begin
        hit     = 1'b1;
        hit_b   = 1'b0;
        hit_idx = 2'd0;
        case (KEY_CODE)
            8'h1D: hit_idx = 2'd0;
            8'h1B: hit_idx = 2'd1;
            8'h1C: hit_idx = 2'd2;
            8'h23: hit_idx = 2'd3;
            8'h43: begin hit_b = 1'b1; hit_idx = 2'd0; end
            8'h42: begin hit_b = 1'b1; hit_idx = 2'd1; end
            8'h3B: begin hit_b = 1'b1; hit_idx = 2'd2; end
            8'h4B: begin hit_b = 1'b1; hit_idx = 2'd3; end
            default: hit = 1'b0;
        endcase
    end

    // Extended-prefix states only consume bytes; they never touch HELD.
    always_comb begin
        pst_d    = pst_q;
        held_a_d = held_a_q;
        held_b_d = held_b_q;
        if (KEY_VALID) begin
            case (pst_q)
                P_IDLE: begin
                    if (KEY_CODE == 8'hF0)      pst_d = P_BRK;
                    else if (KEY_CODE == 8'hE0) pst_d = P_EXT;
                    else if (hit) begin
                        if (hit_b) held_b_d[hit_idx] = 1'b1;
                        else       held_a_d[hit_idx] = 1'b1;
                    end
                end
                P_BRK: begin
                    if (hit) begin
                        if (hit_b) held_b_d[hit_idx] = 1'b0;
                        else       held_a_d[hit_idx] = 1'b0;
                    end
                    pst_d = P_IDLE;
                end
                P_EXT:   pst_d = (KEY_CODE == 8'hF0) ? P_EXTBRK : P_IDLE;
                default: pst_d = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pst_q    <= P_IDLE;
            held_a_q <= 4'd0;
            held_b_q <= 4'd0;
        end else begin
            pst_q    <= pst_d;
            held_a_q <= held_a_d;
            held_b_q <= held_b_d;
        end
    end

    assign req_a = |held_a_q;
    assign req_b = |held_b_q;
    assign dir_a = pick_dir(held_a_q);
    assign dir_b = pick_dir(held_b_q);
    assign hs    = valid_q & MOVE_READY;

    // The second player's direction is snapshotted at the tick so key changes
    // during a stalled handshake cannot alter the pending sequence.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sst_q     <= S_IDLE;
            valid_q   <= 1'b0;
            player_q  <= 1'b0;
            dir_q     <= 2'd0;
            sec_dir_q <= 2'd0;
            both_q    <= 1'b0;
            ptr_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            if (TICK && sst_q != S_IDLE) ovr_q <= 1'b1;
            case (sst_q)
                S_IDLE: begin
                    if (TICK && (req_a || req_b)) begin
                        sst_q   <= S_FIRST;
                        valid_q <= 1'b1;
                        both_q  <= req_a & req_b;
                        if (req_a && req_b) begin
                            player_q  <= ptr_q;
                            dir_q     <= ptr_q ? dir_b : dir_a;
                            sec_dir_q <= ptr_q ? dir_a : dir_b;
                        end else begin
                            player_q <= req_b;
                            dir_q    <= req_b ? dir_b : dir_a;
                        end
                    end
                end
                S_FIRST: begin
                    if (hs) begin
                        if (both_q) begin
                            sst_q    <= S_SECOND;
                            player_q <= ~player_q;
                            dir_q    <= sec_dir_q;
                            ptr_q    <= ~ptr_q;
                        end else begin
                            sst_q   <= S_IDLE;
                            valid_q <= 1'b0;
                        end
                    end
                end
                S_SECOND: begin
                    if (hs) begin
                        sst_q   <= S_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: sst_q <= S_IDLE;
            endcase
        end
    end

    assign MOVE_VALID  = valid_q;
    assign MOVE_PLAYER = player_q;
    assign MOVE_DIR    = dir_q;
    assign HELD_A      = held_a_q;
    assign HELD_B      = held_b_q;
    assign OVERRUN     = ovr_q;

endmodule

// File: tb/tb_ps2_move_arbiter.sv
// Directed bench for ps2_move_arbiter: key parsing, round-robin scheduling, stalls, overrun, reset.
module tb_ps2_move_arbiter;
    logic       CLK = 1'b0;
    logic       RST, KEY_VALID, TICK, MOVE_READY;
    logic [7:0] KEY_CODE;
    logic       MOVE_VALID, MOVE_PLAYER, OVERRUN;
    logic [1:0] MOVE_DIR;
    logic [3:0] HELD_A, HELD_B;

    int tests = 0;
    int fails = 0;

    ps2_move_arbiter dut (
        .CLK(CLK), .RST(RST), .KEY_CODE(KEY_CODE), .KEY_VALID(KEY_VALID),
        .TICK(TICK), .MOVE_VALID(MOVE_VALID), .MOVE_PLAYER(MOVE_PLAYER),
        .MOVE_DIR(MOVE_DIR), .MOVE_READY(MOVE_READY), .HELD_A(HELD_A),
        .HELD_B(HELD_B), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // move packed as {valid, player, dir}
    task automatic chk_mv(input string tag, input logic v, input logic p, input logic [1:0] d);
        chk(tag, {4'd0, MOVE_VALID, MOVE_PLAYER, MOVE_DIR}, {4'd0, v, p, d});
    endtask

    task automatic clk1();
        @(posedge CLK); #1;
    endtask

    task automatic send(input logic [7:0] b);
        KEY_CODE = b; KEY_VALID = 1'b1;
        clk1();
        KEY_VALID = 1'b0;
    endtask

    task automatic tick();
        TICK = 1'b1;
        clk1();
        TICK = 1'b0;
    endtask

    initial begin
        RST = 1'b1; KEY_VALID = 1'b0; TICK = 1'b0; MOVE_READY = 1'b0; KEY_CODE = 8'h00;
        clk1(); clk1();
        chk_mv("reset_move", 1'b0, 1'b0, 2'd0);
        chk("reset_held", {HELD_A, HELD_B}, 8'h00);
        chk("reset_ovr", {7'd0, OVERRUN}, 8'h00);
        RST = 1'b0;

        // round-robin alternation
        MOVE_READY = 1'b1;
        send(8'h1D); send(8'h43);
        chk("held_ab", {HELD_A, HELD_B}, 8'h11);
        tick();   chk_mv("rr1_first", 1'b1, 1'b0, 2'd0);
        clk1();   chk_mv("rr1_second", 1'b1, 1'b1, 2'd0);
        clk1();   chk_mv("rr1_done", 1'b0, 1'b1, 2'd0);
        tick();   chk_mv("rr2_first", 1'b1, 1'b1, 2'd0);
        clk1();   chk_mv("rr2_second", 1'b1, 1'b0, 2'd0);
        clk1();   chk("rr2_done", {7'd0, MOVE_VALID}, 8'h00);
        chk("rr_ovr", {7'd0, OVERRUN}, 8'h00);

        // priority and break codes
        send(8'hF0); send(8'h1D); send(8'hF0); send(8'h43);
        chk("released", {HELD_A, HELD_B}, 8'h00);
        send(8'h1C); send(8'h1B);
        chk("held_ld", {4'd0, HELD_A}, 8'h06);
        tick();   chk_mv("prio_down", 1'b1, 1'b0, 2'd1);
        clk1();   chk("single_done", {7'd0, MOVE_VALID}, 8'h00);
        send(8'hF0); send(8'h1B);
        tick();   chk_mv("prio_left", 1'b1, 1'b0, 2'd2);
        clk1();
        send(8'hF0); send(8'h1C);
        chk("held_empty", {4'd0, HELD_A}, 8'h00);
        tick();   chk("no_req_tick", {7'd0, MOVE_VALID}, 8'h00);
        clk1();   chk("no_req_tick2", {7'd0, MOVE_VALID}, 8'h00);

        // extended keys never touch HELD
        send(8'hE0); send(8'h1D);
        chk("ext_make", {4'd0, HELD_A}, 8'h00);
        send(8'hE0); send(8'hF0); send(8'h1D);
        chk("ext_break", {4'd0, HELD_A}, 8'h00);
        send(8'h23);
        chk("after_ext", {4'd0, HELD_A}, 8'h08);
        send(8'hF0); send(8'h23);

        // stall with overrun; PTR is 0 here
        send(8'h1D); send(8'h3B);
        MOVE_READY = 1'b0;
        tick();   chk_mv("stall_first", 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) TICK = 1'b1;
            if (i == 3) begin KEY_CODE = 8'h4B; KEY_VALID = 1'b1; end
            clk1();
            TICK = 1'b0; KEY_VALID = 1'b0;
            chk_mv("stall_hold", 1'b1, 1'b0, 2'd0);
        end
        chk("ovr_set", {7'd0, OVERRUN}, 8'h01);
        MOVE_READY = 1'b1;
        clk1();   chk_mv("stall_second", 1'b1, 1'b1, 2'd2);
        clk1();   chk("stall_done", {7'd0, MOVE_VALID}, 8'h00);
        clk1();   chk("no_third", {7'd0, MOVE_VALID}, 8'h00);

        // TICK and key on same cycle; PTR is 1 here
        send(8'hF0); send(8'h1D); send(8'hF0); send(8'h3B); send(8'hF0); send(8'h4B);
        chk("cleared", {HELD_A, HELD_B}, 8'h00);
        KEY_CODE = 8'h1D; KEY_VALID = 1'b1; TICK = 1'b1;
        clk1();
        KEY_VALID = 1'b0; TICK = 1'b0;
        chk("same_cycle_mv", {7'd0, MOVE_VALID}, 8'h00);
        chk("same_cycle_held", {4'd0, HELD_A}, 8'h01);
        tick();   chk_mv("late_tick", 1'b1, 1'b0, 2'd0);
        clk1();

        // reset mid-sequence in S_SECOND
        send(8'h43);
        tick();   chk_mv("ptr1_first", 1'b1, 1'b1, 2'd0);
        clk1();   chk_mv("ptr1_second", 1'b1, 1'b0, 2'd0);
        RST = 1'b1;
        clk1();
        RST = 1'b0;
        chk_mv("rst_move", 1'b0, 1'b0, 2'd0);
        chk("rst_held", {HELD_A, HELD_B}, 8'h00);
        chk("rst_ovr", {7'd0, OVERRUN}, 8'h00);
        send(8'h1D); send(8'h43);
        tick();   chk_mv("rst_ptr", 1'b1, 1'b0, 2'd0);
        clk1();   chk_mv("rst_ptr2", 1'b1, 1'b1, 2'd0);
        clk1();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
